maj_net_eval: RTL and testbench
===============================

MAJ_NET_EVAL -- requirements
Module: maj_net_eval

Interface
REQ-001 Parameter NIN, default 7: number of primary inputs, range 1..12.
REQ-002 Parameter NGATE, default 6: number of MAJ3 gates in the programmable network, range 1..32.
REQ-003 Derived constant SW = clog2(1+NIN+NGATE): selector width; CW = 3*(SW+1): gate config word width.
REQ-004 clk  input  1  sole clock, all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cfg_we  input  1  write strobe for the gate config table.
REQ-007 cfg_addr  input  clog2(NGATE)  gate index written.
REQ-008 cfg_data  input  CW  three operands {inv,sel}; operand a in the LSBs.
REQ-009 cfg_err  output  1  sticky flag: an illegal selector was used during evaluation.
REQ-010 in_valid  input  1  a request is offered.
REQ-011 in_ready  output  1  the block accepts a request.
REQ-012 in_x  input  NIN  input vector for eval mode.
REQ-013 in_mode  input  1  0 = eval single vector; 1 = sweep all 2^NIN vectors.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_bit  output  1  eval result: value of gate NGATE-1.
REQ-017 out_count  output  NIN+1  sweep result: number of vectors on which gate NGATE-1 = 1.

Function
REQ-018 Operand value: sel 0 = const 0; sel 1..NIN = x[sel-1]; sel NIN+1..NIN+NGATE = gate[sel-NIN-1]; the value is XORed with inv.
REQ-019 Gate k = MAJ(a,b,c) = ab | ac | bc of its three operand values.
REQ-020 Any selector referencing gate j >= k, or sel > NIN+NGATE, yields 0 and sets cfg_err to 1 until reset.
REQ-021 States: IDLE, EVAL, SWEEP, HOLD; in_ready = 1 only in IDLE; out_valid = 1 only in HOLD.
REQ-022 cfg_we is honoured only in IDLE; in any other state it is ignored and the table is unchanged.
REQ-023 cfg_we and an accepted request in the same IDLE cycle: the write takes effect; the request uses the new table.
REQ-024 An IDLE cycle with in_valid=1 captures in_x and in_mode, then moves to EVAL (mode 0) or SWEEP (mode 1) with gate index k = 0.
REQ-025 EVAL evaluates exactly one gate per cycle in index order k = 0..NGATE-1, storing each result in a gate-value register.
REQ-026 After gate NGATE-1 is evaluated, the block enters HOLD with out_bit set; out_valid rises exactly NGATE cycles after the acceptance edge.
REQ-027 SWEEP applies vectors p = 0..2^NIN-1 in ascending order, using NGATE cycles per vector.
REQ-028 In SWEEP, out_count increments when gate NGATE-1 = 1; out_valid rises NGATE*2^NIN cycles after the acceptance edge.
REQ-029 In SWEEP, out_count saturates never: width NIN+1 holds 2^NIN exactly.
REQ-030 In EVAL, out_count is unchanged; in SWEEP, out_bit is the value for the last vector (p = 2^NIN-1).
REQ-031 HOLD keeps out_bit and out_count stable while out_ready = 0; out_valid & out_ready returns the block to IDLE on the next edge.
REQ-032 No request overlap: in_valid while busy is not accepted and is not queued.

Reset
REQ-033 rst=1 at any time, including mid-EVAL or mid-SWEEP, forces IDLE immediately: in_ready=1, out_valid=0, out_bit=0, out_count=0, cfg_err=0, k=0, p=0.
REQ-034 rst clears every config word to 0, so every gate is MAJ(0,0,0) = 0; an in-flight result is discarded.

Verification
REQ-035 NIN=7, NGATE=6; gate0 = MAJ(x0,x1,x2); gates1..5 = MAJ(g[k-1],g[k-1],0); eval in_x=7'b0000011 -> out_bit=1 six cycles later; in_x=7'b0000001 -> out_bit=0.
REQ-036 Same config, sweep -> out_count=64 after 6*128=768 cycles; out_ready held 0 for 10 cycles -> values stable and out_valid stays 1.
REQ-037 gate0 = MAJ(inv x0, const0, inv const0), others pass-through; sweep -> out_count=64; eval in_x=0 -> out_bit=1.
REQ-038 gate0 operand a selects gate2 -> cfg_err=1 after eval; cfg_err stays 1 over later requests until rst.
REQ-039 rst asserted at cycle 300 of a sweep -> out_valid=0 and in_ready=1 immediately; next sweep with default table -> out_count=0.
REQ-040 cfg_we during EVAL -> table unchanged (read-back via a subsequent eval); cfg_we with a simultaneous IDLE request -> the request uses the new word.

Source files
------------

// File: rtl/maj_net_eval.sv
// maj_net_eval: programmable network of MAJ3 gates, evaluated one gate per cycle,
// either for a single input vector or swept over all 2^NIN vectors with a ones count.
module maj_net_eval #(
    parameter int NIN = 7,
    parameter int NGATE = 6,
    localparam int SW = $clog2(1 + NIN + NGATE),
    localparam int CW = 3 * (SW + 1),
    localparam int AW = (NGATE > 1) ? $clog2(NGATE) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [CW-1:0]   cfg_data,
    output logic            cfg_err,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NIN-1:0]  in_x,
    input  logic            in_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic [NIN:0]    out_count
);
    typedef enum logic [1:0] {IDLE, EVAL, SWEEP, HOLD} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_cfg [NGATE];
    logic [NGATE-1:0] r_g;
    logic [NIN-1:0] r_x, r_p, w_x;
    logic [AW-1:0] r_k;
    logic r_mode, r_bit, r_err;
    logic [NIN:0] r_cnt;
    logic [2**SW-1:0] w_v;
    logic [2:0][SW-1:0] w_sel;
    logic [2:0] w_inv, w_bad, w_op;
    logic w_gate, w_last, w_busy;
    // Operand space: bit 0 = const 0, then inputs, then gate values; a selector is
    // legal only if it points below the gate currently being evaluated.
    always_comb begin
        w_x = r_mode ? r_p : r_x;
        w_v = '0;
        w_v[NIN+NGATE:0] = {r_g, w_x, 1'b0};
        for (int i = 0; i < 3; i++) begin
            w_sel[i] = r_cfg[r_k][i*(SW+1) +: SW];
            w_inv[i] = r_cfg[r_k][i*(SW+1)+SW];
            w_bad[i] = int'(w_sel[i]) > NIN + int'(r_k);
            w_op[i] = (w_bad[i] ? 1'b0 : w_v[w_sel[i]]) ^ w_inv[i];
        end
        w_gate = (w_op[0] & w_op[1]) | (w_op[0] & w_op[2]) | (w_op[1] & w_op[2]);
        w_last = int'(r_k) == NGATE - 1;
        w_busy = r_state == EVAL || r_state == SWEEP;
        w_next = r_state;
        if (r_state == IDLE && in_valid) w_next = in_mode ? SWEEP : EVAL;
        if (r_state == EVAL && w_last) w_next = HOLD;
        if (r_state == SWEEP && w_last && &r_p) w_next = HOLD;
        if (r_state == HOLD && out_ready) w_next = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NGATE; i++) r_cfg[i] <= '0;
            r_g <= '0;
            r_x <= '0;
            r_p <= '0;
            r_k <= '0;
            r_mode <= 1'b0;
            r_bit <= 1'b0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (cfg_we && int'(cfg_addr) < NGATE) r_cfg[cfg_addr] <= cfg_data;
                if (in_valid) begin
                    r_x <= in_x;
                    r_mode <= in_mode;
                    r_k <= '0;
                    r_p <= '0;
                    if (in_mode) r_cnt <= '0;
                end
            end
            if (w_busy) begin
                r_g[r_k] <= w_gate;
                if (|w_bad) r_err <= 1'b1;
                r_k <= w_last ? '0 : r_k + AW'(1);
                if (w_last) begin
                    r_bit <= w_gate;
                    if (r_mode) begin
                        r_cnt <= r_cnt + {{NIN{1'b0}}, w_gate};
                        r_p <= r_p + NIN'(1);
                    end
                end
            end
        end
    end
    assign in_ready = r_state == IDLE;
    assign out_valid = r_state == HOLD;
    assign out_bit = r_bit;
    assign out_count = r_cnt;
    assign cfg_err = r_err;
endmodule

// File: tb/tb_maj_net_eval.sv
// tb_maj_net_eval: randomized and directed checks of maj_net_eval against a
// behavioural model that evaluates the whole gate network as plain arithmetic.
module tb_maj_net_eval;
    localparam int NIN = 7;
    localparam int NGATE = 6;
    localparam int FW = 5;
    localparam int CW = 15;
    logic clk, rst, cfg_we, cfg_err, in_valid, in_ready, in_mode, out_valid, out_ready, out_bit;
    logic [2:0] cfg_addr;
    logic [CW-1:0] cfg_data;
    logic [NIN-1:0] in_x;
    logic [NIN:0] out_count;
    logic [CW-1:0] m_tbl [NGATE];
    logic m_err;
    int total, bad;

    maj_net_eval #(.NIN(NIN), .NGATE(NGATE)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .out_count(out_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] op(input int inv, input int sel);
        return {inv[0], sel[3:0]};
    endfunction

    // returns {illegal selector seen, value of the last gate}
    function automatic logic [1:0] model(input logic [NIN-1:0] x);
        int g[NGATE];
        int s, v, n;
        logic e;
        e = 0;
        for (int k = 0; k < NGATE; k++) begin
            n = 0;
            for (int i = 0; i < 3; i++) begin
                s = int'(m_tbl[k][i*FW +: 4]);
                if (s == 0) v = 0;
                else if (s <= NIN) v = int'(x[s-1]);
                else if (s - NIN - 1 < k) v = g[s-NIN-1];
                else begin
                    v = 0;
                    e = 1;
                end
                n += v ^ int'(m_tbl[k][i*FW+4]);
            end
            g[k] = (n >= 2) ? 1 : 0;
        end
        return {e, g[NGATE-1] != 0};
    endfunction

    function automatic int msweep();
        logic [1:0] r;
        int c;
        c = 0;
        for (int p = 0; p < 2**NIN; p++) begin
            r = model(NIN'(p));
            c += int'(r[0]);
        end
        return c;
    endfunction

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        rst = 0;
        m_err = 0;
        for (int i = 0; i < NGATE; i++) m_tbl[i] = '0;
    endtask

    task automatic wr(input int a, input logic [CW-1:0] d);
        cfg_we = 1;
        cfg_addr = a[2:0];
        cfg_data = d;
        @(negedge clk);
        cfg_we = 0;
        m_tbl[a] = d;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic req(input logic [NIN-1:0] x, input logic mode, output int lat);
        logic [1:0] r;
        r = model(x);
        m_err = m_err | r[1];
        in_valid = 1;
        in_x = x;
        in_mode = mode;
        @(negedge clk);
        in_valid = 0;
        wait_out(lat);
    endtask

    task automatic take();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        m_err = 0;
        for (int i = 0; i < NGATE; i++) m_tbl[i] = '0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_bit !== 1'b0) begin bad++; $display("FAIL rst_out_bit got=%b exp=0", out_bit); end
        total++; if (out_count !== 8'd0) begin bad++; $display("FAIL rst_out_count got=%0d exp=0", out_count); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); end
    endtask

    task automatic test_chain();
        logic [NIN-1:0] xs[2];
        logic [1:0] e;
        int lat;
        xs[0] = 7'b0000011;
        xs[1] = 7'b0000001;
        wr(0, {op(0, 3), op(0, 2), op(0, 1)});
        for (int k = 1; k < NGATE; k++) wr(k, {op(0, 0), op(0, 7 + k), op(0, 7 + k)});
        for (int i = 0; i < 2; i++) begin
            e = model(xs[i]);
            req(xs[i], 0, lat);
            total++; if (lat != NGATE) begin bad++; $display("FAIL chain_lat got=%0d exp=%0d", lat, NGATE); end
            total++; if (out_bit !== e[0]) begin bad++; $display("FAIL chain_bit x=%b got=%b exp=%b", xs[i], out_bit, e[0]); end
            total++; if (out_count !== 8'd0) begin bad++; $display("FAIL chain_count got=%0d exp=0", out_count); end
            take();
        end
    endtask

    task automatic test_sweep_hold();
        logic [1:0] e;
        int c, lat;
        c = msweep();
        e = model(7'h7f);
        req('0, 1, lat);
        total++; if (lat != NGATE * 128) begin bad++; $display("FAIL sweep_lat got=%0d exp=%0d", lat, NGATE * 128); end
        total++; if (int'(out_count) != c) begin bad++; $display("FAIL sweep_count got=%0d exp=%0d", out_count, c); end
        total++; if (out_bit !== e[0]) begin bad++; $display("FAIL sweep_bit got=%b exp=%b", out_bit, e[0]); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || int'(out_count) != c || out_bit !== e[0]) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d got v=%b c=%0d b=%b exp v=1 c=%0d b=%b", i, out_valid, out_count, out_bit, c, e[0]);
            end
        end
        take();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release got=%b exp=1", in_ready); end
    endtask

    task automatic test_inv();
        logic [1:0] e;
        int c, lat;
        wr(0, {op(1, 0), op(0, 0), op(1, 1)});
        c = msweep();
        req('0, 1, lat);
        total++; if (int'(out_count) != c) begin bad++; $display("FAIL inv_count got=%0d exp=%0d", out_count, c); end
        take();
        e = model('0);
        req('0, 0, lat);
        total++; if (out_bit !== e[0]) begin bad++; $display("FAIL inv_bit got=%b exp=%b", out_bit, e[0]); end
        take();
    endtask

    task automatic test_cfg_guard();
        logic [1:0] e;
        logic [CW-1:0] one;
        int lat;
        one = {op(1, 0), op(1, 0), op(1, 0)};
        e = model(7'd1);
        in_valid = 1; in_x = 7'd1; in_mode = 0;
        @(negedge clk);
        in_valid = 0;
        cfg_we = 1; cfg_addr = 3'd5; cfg_data = one;
        @(negedge clk);
        cfg_we = 0;
        wait_out(lat);
        total++; if (out_bit !== e[0]) begin bad++; $display("FAIL busy_write_bit got=%b exp=%b", out_bit, e[0]); end
        take();
        req(7'd1, 0, lat);
        total++; if (out_bit !== e[0]) begin bad++; $display("FAIL busy_write_readback got=%b exp=%b", out_bit, e[0]); end
        take();
        m_tbl[5] = one;
        e = model(7'd1);
        cfg_we = 1; cfg_addr = 3'd5; cfg_data = one;
        in_valid = 1; in_x = 7'd1; in_mode = 0;
        @(negedge clk);
        cfg_we = 0; in_valid = 0;
        wait_out(lat);
        total++; if (out_bit !== e[0]) begin bad++; $display("FAIL same_cycle_write got=%b exp=%b", out_bit, e[0]); end
        take();
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        int lat;
        logic seen;
        wr(5, {op(0, 0), op(0, 12), op(0, 12)});
        e = model('0);
        in_valid = 1; in_x = '0; in_mode = 0;
        @(negedge clk);
        in_x = 7'd1;
        lat = 0;
        while (!out_valid && lat < 2000) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", in_ready); end
            @(negedge clk);
            lat++;
        end
        in_valid = 0;
        total++; if (out_bit !== e[0]) begin bad++; $display("FAIL b2b_bit got=%b exp=%b", out_bit, e[0]); end
        take();
        seen = 0;
        repeat (NGATE + 2) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL b2b_queued got=%b exp=0", seen); end
    endtask

    task automatic test_err();
        int lat;
        total++; if (cfg_err !== m_err) begin bad++; $display("FAIL err_pre got=%b exp=%b", cfg_err, m_err); end
        wr(0, {op(0, 0), op(0, 0), op(0, 10)});
        req(7'h15, 0, lat);
        total++; if (cfg_err !== m_err) begin bad++; $display("FAIL err_set got=%b exp=%b", cfg_err, m_err); end
        take();
        wr(0, {op(0, 3), op(0, 2), op(0, 1)});
        req(7'h03, 0, lat);
        total++; if (cfg_err !== m_err) begin bad++; $display("FAIL err_sticky got=%b exp=%b", cfg_err, m_err); end
        take();
        do_reset();
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", cfg_err); end
    endtask

    task automatic test_rst_mid_sweep();
        int c, lat;
        wr(0, {op(0, 3), op(0, 2), op(0, 1)});
        in_valid = 1; in_x = '0; in_mode = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (299) @(negedge clk);
        rst = 1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
        total++; if (out_count !== 8'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", out_count); end
        @(negedge clk);
        rst = 0;
        m_err = 0;
        for (int i = 0; i < NGATE; i++) m_tbl[i] = '0;
        c = msweep();
        req('0, 1, lat);
        total++; if (int'(out_count) != c) begin bad++; $display("FAIL default_sweep got=%0d exp=%0d", out_count, c); end
        total++; if (out_bit !== 1'b0) begin bad++; $display("FAIL default_bit got=%b exp=0", out_bit); end
        take();
    endtask

    task automatic test_random();
        logic [1:0] e;
        logic [NIN-1:0] x;
        int c, lat, s;
        logic [14:0] w;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < NGATE; k++) begin
                w = '0;
                for (int i = 0; i < 3; i++) begin
                    s = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, NIN + k));
                    w[i*FW +: FW] = op(int'($urandom_range(0, 1)), s);
                end
                wr(k, w);
            end
            for (int j = 0; j < 5; j++) begin
                x = NIN'($urandom);
                e = model(x);
                req(x, 0, lat);
                total++; if (lat != NGATE) begin bad++; $display("FAIL rnd_lat got=%0d exp=%0d", lat, NGATE); end
                total++; if (out_bit !== e[0]) begin bad++; $display("FAIL rnd_bit t=%0d x=%b got=%b exp=%b", t, x, out_bit, e[0]); end
                total++; if (cfg_err !== m_err) begin bad++; $display("FAIL rnd_err got=%b exp=%b", cfg_err, m_err); end
                take();
            end
            if (t < 2) begin
                c = msweep();
                req(NIN'($urandom), 1, lat);
                total++; if (int'(out_count) != c) begin bad++; $display("FAIL rnd_sweep t=%0d got=%0d exp=%0d", t, out_count, c); end
                take();
            end
        end
    endtask

    initial begin
        rst = 1; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
        in_valid = 0; in_x = '0; in_mode = 0; out_ready = 0;
        total = 0; bad = 0;
        test_reset();
        test_chain();
        test_sweep_hold();
        test_inv();
        test_cfg_guard();
        test_back_to_back();
        test_err();
        test_rst_mid_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
